vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen_if.sv | 31 +++
 rtl/vga_sync_gen.sv | 77 +++++++
 tb/tb_vga_sync_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// VGA timing bundle: sync strobes, pixel enable and raster position.
// The generator drives it through master; displays and pixel pipelines use slave.
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       frame_tick;

  modport master (
    output hsync,
    output vsync,
    output video_on,
    output p_tick,
    output pix_x,
    output pix_y,
    output frame_tick
  );

  modport slave (
    input hsync,
    input vsync,
    input video_on,
    input p_tick,
    input pix_x,
    input pix_y,
    input frame_tick
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator; clk runs at twice the pixel rate.
// Sync outputs are registered from next-state counts so they align with pix_x/pix_y.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic          clk,
  input  logic          reset_n,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] H_VLAST  = 10'(H_DISPLAY - 1);
  localparam logic [9:0] V_VLAST  = 10'(V_DISPLAY - 1);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic       div_q;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (div_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    hs_d = !((h_d >= HS_START) && (h_d <= HS_END));
    vs_d = !((v_d >= VS_START) && (v_d <= VS_END));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      div_q <= ~div_q;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign vga.p_tick     = div_q;
  assign vga.pix_x      = h_q;
  assign vga.pix_y      = v_q;
  assign vga.hsync      = hs_q;
  assign vga.vsync      = vs_q;
  assign vga.video_on   = (h_q < H_VIS) && (v_q < V_VIS);
  assign vga.frame_tick = div_q && (h_q == H_VLAST) && (v_q == V_VLAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 timing and a tiny 8x4 raster side by side.
// Expected outputs come from a closed-form model of clk edges since reset release.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       pt;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       ft;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  vga_sync_gen_if vb ();
  vga_sync_gen_if vt ();

  vga_sync_gen u_big (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (vb)
  );

  vga_sync_gen #(
    .H_DISPLAY (8),
    .H_FRONT   (1),
    .H_SYNC    (2),
    .H_BACK    (1),
    .V_DISPLAY (4),
    .V_FRONT   (1),
    .V_SYNC    (1),
    .V_BACK    (1)
  ) u_tiny (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (vt)
  );

  always #5 clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   n        = 0;
  obs_t qb[$];
  obs_t qt[$];

  function automatic obs_t model(input int cyc, input int hd, input int hf,
                                 input int hsw, input int hbk, input int vd,
                                 input int vf, input int vsw, input int vbk);
    obs_t m;
    int ht, vtot, p, h, v;
    ht   = hd + hf + hsw + hbk;
    vtot = vd + vf + vsw + vbk;
    p    = cyc / 2;
    h    = p % ht;
    v    = (p / ht) % vtot;
    m.pt = (cyc % 2) == 1;
    m.hs = !((h >= hd + hf) && (h < hd + hf + hsw));
    m.vs = !((v >= vd + vf) && (v < vd + vf + vsw));
    m.vo = (h < hd) && (v < vd);
    m.ft = m.pt && (h == hd - 1) && (v == vd - 1);
    m.x  = 10'(h);
    m.y  = 10'(v);
    return m;
  endfunction

  function automatic obs_t exp_big(input int cyc);
    return model(cyc, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic obs_t exp_tiny(input int cyc);
    return model(cyc, 8, 1, 2, 1, 4, 1, 1, 1);
  endfunction

  function automatic obs_t get_big();
    obs_t o;
    o = {vb.p_tick, vb.hsync, vb.vsync, vb.video_on, vb.frame_tick,
         vb.pix_x, vb.pix_y};
    return o;
  endfunction

  function automatic obs_t get_tiny();
    obs_t o;
    o = {vt.p_tick, vt.hsync, vt.vsync, vt.video_on, vt.frame_tick,
         vt.pix_x, vt.pix_y};
    return o;
  endfunction

  task automatic chk_obs(input string tag, input obs_t got, input obs_t exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s n=%0d got pt%b hs%b vs%b vo%b ft%b x%0d y%0d exp pt%b hs%b vs%b vo%b ft%b x%0d y%0d",
             tag, n, got.pt, got.hs, got.vs, got.vo, got.ft, got.x, got.y,
             exp.pt, exp.hs, exp.vs, exp.vo, exp.ft, exp.x, exp.y);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    n++;
    qb.push_back(exp_big(n));
    qt.push_back(exp_tiny(n));
    @(negedge clk);
    chk_obs("big", get_big(), qb.pop_front());
    chk_obs("tiny", get_tiny(), qt.pop_front());
  endtask

  int  hb_low   = 0;
  int  th_low   = 0;
  int  tv_low   = 0;
  int  first_y1 = -1;
  int  ft_last  = -1;
  int  ft_cnt   = 0;
  int  bft_cnt  = 0;
  bit  found;

  initial begin
    #12;
    qb.push_back(exp_big(0));
    qt.push_back(exp_tiny(0));
    chk_obs("reset_big", get_big(), qb.pop_front());
    chk_obs("reset_tiny", get_tiny(), qt.pop_front());

    @(negedge clk);
    reset_n = 1'b1;
    n = 0;

    for (int i = 0; i < 3300; i++) begin
      cycle();
      if (n < 1600 && !vb.hsync) hb_low++;
      if (first_y1 < 0 && vb.pix_y == 10'd1) begin
        first_y1 = n;
        chk_int("big_wrap_x", int'(vb.pix_x), 0);
      end
      if (vb.frame_tick) bft_cnt++;
      if (n < 24 && !vt.hsync) th_low++;
      if (n < 168 && !vt.vsync) tv_low++;
      if (vt.frame_tick) begin
        if (ft_last < 0) chk_int("tiny_ft_first", n, 87);
        else chk_int("tiny_ft_gap", n - ft_last, 168);
        ft_last = n;
        ft_cnt++;
      end
    end

    chk_int("big_line_period", first_y1, 1600);
    chk_int("big_hsync_low", hb_low, 192);
    chk_int("big_no_ftick", bft_cnt, 0);
    chk_int("tiny_hsync_low", th_low, 4);
    chk_int("tiny_vsync_low", tv_low, 24);
    chk_int("tiny_ft_count", ft_cnt, 20);

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cycle();
      if (vb.pix_x == 10'd700 && vb.p_tick) found = 1'b1;
    end
    chk_int("reach_x700", int'(found), 1);

    #2;
    reset_n = 1'b0;
    #1;
    qb.push_back(exp_big(0));
    qt.push_back(exp_tiny(0));
    chk_obs("async_rst_big", get_big(), qb.pop_front());
    chk_obs("async_rst_tiny", get_tiny(), qt.pop_front());

    @(posedge clk);
    @(negedge clk);
    chk_obs("held_rst_big", get_big(), exp_big(0));
    reset_n = 1'b1;
    n = 0;

    for (int i = 0; i < 40; i++) begin
      cycle();
      if (n == 1) begin
        chk_int("rel_ptick", int'(vb.p_tick), 1);
        chk_int("rel_x0", int'(vb.pix_x), 0);
      end
      if (n == 2) chk_int("rel_x1", int'(vb.pix_x), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
